keypad_password_capture: RTL and testbench

//   Upstream stage of controlador_estacionamiento: collects BCD digits from the parking keypad.

---
 rtl/keypad_password_capture.sv | 181 ++++++++++++++++++
 tb/tb_keypad_password_capture.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_password_capture.sv
// keypad_password_capture
//   Collects debounced BCD digits from the parking keypad and packs them with
//   the first digit at the MSB. When the driver presses enter after exactly
//   DIGITS digits, the packed value is copied to password_input and pwd_valid
//   pulses for one cycle. Short submits, extra digits and idle timeouts pulse
//   entry_error instead. While the controller reports alarm_blocked (lock_in)
//   the keypad is ignored and any partial entry is discarded.
//
// Optional feature macro: KEYPAD_BACKSPACE_EN
//   defined   : key 0xC in ENTRY removes the most recent digit
//   undefined : key 0xC is a reserved code, ignored in every state
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous reset, active-low
//   key_valid       key_code valid this cycle
//   key_code        0-9 digit, 0xA clear, 0xB enter, 0xC backspace, 0xD-0xF reserved
//   lock_in         1 = keypad locked out (controller alarm_blocked)
//   password_input  last submitted password, held until the next submit
//   pwd_valid       1-cycle strobe: password_input newly updated
//   entry_error     1-cycle strobe: short submit, overflow digit or timeout
//   digit_count     digits currently buffered (saturates at DIGITS)
//   busy            1 while an entry is in progress
module keypad_password_capture #(
  parameter int DIGITS         = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  localparam int PW_W          = 4 * DIGITS,
  localparam int CNT_W         = $clog2(DIGITS + 1),
  localparam int TMR_W         = $clog2(TIMEOUT_CYCLES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  input  logic             lock_in,
  output logic [PW_W-1:0]  password_input,
  output logic             pwd_valid,
  output logic             entry_error,
  output logic [CNT_W-1:0] digit_count,
  output logic             busy
);

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;
`ifdef KEYPAD_BACKSPACE_EN
  localparam logic [3:0] KEY_BKSP  = 4'hC;
`endif

  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DIGITS);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENTRY  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [PW_W-1:0]  shift_buf, shift_buf_n;
  logic [PW_W-1:0]  pw_n;
  logic [CNT_W-1:0] count_n;
  logic [TMR_W-1:0] timer, timer_n;
  logic             valid_n, err_n;
  logic             is_digit;

  assign is_digit = (key_code <= 4'd9);
  assign busy     = (state == ENTRY);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      shift_buf      <= '0;
      password_input <= '0;
      pwd_valid      <= 1'b0;
      entry_error    <= 1'b0;
      digit_count    <= '0;
      timer          <= '0;
    end else begin
      state          <= state_n;
      shift_buf      <= shift_buf_n;
      password_input <= pw_n;
      pwd_valid      <= valid_n;
      entry_error    <= err_n;
      digit_count    <= count_n;
      timer          <= timer_n;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_n     = state;
    shift_buf_n = shift_buf;
    pw_n        = password_input;
    count_n     = digit_count;
    timer_n     = timer;
    valid_n     = 1'b0;
    err_n       = 1'b0;

    unique case (state)
      IDLE: begin
        timer_n = '0;
        if (key_valid) begin
          if (is_digit) begin
            shift_buf_n = PW_W'(key_code);
            count_n     = CNT_W'(1);
            state_n     = ENTRY;
          end else if (key_code == KEY_ENTER) begin
            err_n = 1'b1;  // nothing buffered: always a short submit
          end
        end
      end

      ENTRY: begin
        if (key_valid && is_digit) begin
          // Any digit counts as activity, even one dropped on overflow.
          timer_n = '0;
          if (digit_count < CNT_FULL) begin
            shift_buf_n = (shift_buf << 4) | PW_W'(key_code);
            count_n     = digit_count + CNT_W'(1);
          end else begin
            err_n = 1'b1;
          end
        end else if (key_valid && key_code == KEY_ENTER) begin
          if (digit_count == CNT_FULL) begin
            pw_n    = shift_buf;
            valid_n = 1'b1;
          end else begin
            err_n = 1'b1;
          end
          shift_buf_n = '0;
          count_n     = '0;
          timer_n     = '0;
          state_n     = IDLE;
        end else if (key_valid && key_code == KEY_CLEAR) begin
          shift_buf_n = '0;
          count_n     = '0;
          timer_n     = '0;
          state_n     = IDLE;
`ifdef KEYPAD_BACKSPACE_EN
        end else if (key_valid && key_code == KEY_BKSP) begin
          // digit_count is at least 1 in ENTRY, so the decrement cannot wrap.
          shift_buf_n = shift_buf >> 4;
          count_n     = digit_count - CNT_W'(1);
          timer_n     = '0;
          if (digit_count == CNT_W'(1)) state_n = IDLE;
`endif
        end else if (timer == TMR_LAST) begin
          // Reserved codes are not activity and fall through to here.
          shift_buf_n = '0;
          count_n     = '0;
          timer_n     = '0;
          err_n       = 1'b1;
          state_n     = IDLE;
        end else begin
          timer_n = timer + TMR_W'(1);
        end
      end

      LOCKED: begin
        if (!lock_in) state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase

    // Lockout overrides everything decided above, including a same-cycle key.
    if (lock_in) begin
      state_n     = LOCKED;
      shift_buf_n = '0;
      count_n     = '0;
      timer_n     = '0;
      pw_n        = password_input;
      valid_n     = 1'b0;
      err_n       = 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_password_capture.sv
// tb_keypad_password_capture
//   Directed stimulus for keypad_password_capture. Each key that should cause
//   a strobe pushes the expected event (kind + password_input value) into a
//   queue; a monitor on the falling edge pops and compares whenever the DUT
//   raises pwd_valid or entry_error. Build with +define+KEYPAD_BACKSPACE_EN to
//   exercise the backspace variant.
module tb_keypad_password_capture;

  localparam int DIGITS         = 4;
  localparam int TIMEOUT_CYCLES = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic        lock_in = 1'b0;
  logic [15:0] password_input;
  logic        pwd_valid;
  logic        entry_error;
  logic [2:0]  digit_count;
  logic        busy;

  typedef struct packed {
    logic        is_err;
    logic [15:0] pw;
  } ev_t;

  ev_t         exp_q[$];
  logic [15:0] exp_pw = 16'h0000;
  int          n_checks = 0;
  int          n_pass = 0;

  keypad_password_capture #(
    .DIGITS(DIGITS),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_valid(key_valid),
    .key_code(key_code),
    .lock_in(lock_in),
    .password_input(password_input),
    .pwd_valid(pwd_valid),
    .entry_error(entry_error),
    .digit_count(digit_count),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Expected-event helpers: a valid strobe updates the held password,
  // an error strobe must leave it untouched.
  task automatic expect_valid(input logic [15:0] pw);
    exp_pw = pw;
    exp_q.push_back('{is_err: 1'b0, pw: pw});
  endtask

  task automatic expect_error();
    exp_q.push_back('{is_err: 1'b1, pw: exp_pw});
  endtask

  // Called at posedge+1; key is sampled on the next rising edge and the
  // task returns at posedge+1 with the resulting registered outputs visible.
  task automatic press(input logic [3:0] code);
    key_valid = 1'b1;
    key_code  = code;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst && (pwd_valid === 1'b1 || entry_error === 1'b1)) begin
      check("strobe_exclusive", {31'd0, pwd_valid & entry_error}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {30'd0, pwd_valid, entry_error}, 32'd0);
      end else begin
        ev_t ev;
        ev = exp_q.pop_front();
        check("strobe_kind_err", {31'd0, entry_error}, {31'd0, ev.is_err});
        check("password_input", {16'd0, password_input}, {16'd0, ev.pw});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    #12;
    check("rst_password", {16'd0, password_input}, 32'h0);
    check("rst_pwd_valid", {31'd0, pwd_valid}, 32'd0);
    check("rst_entry_error", {31'd0, entry_error}, 32'd0);
    check("rst_count", {29'd0, digit_count}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;

    // 1: full password.
    press(4'h3); press(4'h7); press(4'h6);
    check("t1_count3", {29'd0, digit_count}, 32'd3);
    check("t1_busy", {31'd0, busy}, 32'd1);
    press(4'h1);
    expect_valid(16'h3761);
    press(4'hB);
    check("t1_busy_after", {31'd0, busy}, 32'd0);
    check("t1_count_after", {29'd0, digit_count}, 32'd0);
    idle(2);

    // 2: short submit keeps the previous password.
    press(4'h3); press(4'h7);
    expect_error();
    press(4'hB);
    check("t2_count", {29'd0, digit_count}, 32'd0);
    idle(2);

    // Enter from IDLE, and reserved/clear codes ignored in IDLE.
    press(4'hE); press(4'hA);
    check("idle_ignore_busy", {31'd0, busy}, 32'd0);
    expect_error();
    press(4'hB);
    idle(2);

    // 3: overflow digit dropped, buffer kept.
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    expect_error();
    press(4'h5);
    check("t3_count_sat", {29'd0, digit_count}, 32'd4);
    expect_valid(16'h1234);
    press(4'hB);
    idle(2);

    // 4: timeout boundary.
    press(4'h9);
    expect_error();
    idle(TIMEOUT_CYCLES - 1);
    check("t4_pre_expiry_busy", {31'd0, busy}, 32'd1);
    check("t4_pre_expiry_err", {31'd0, entry_error}, 32'd0);
    idle(1);
    check("t4_expiry_err", {31'd0, entry_error}, 32'd1);
    check("t4_count", {29'd0, digit_count}, 32'd0);
    check("t4_busy", {31'd0, busy}, 32'd0);
    idle(2);
    press(4'h1); press(4'h1); press(4'h1); press(4'h1);
    expect_valid(16'h1111);
    press(4'hB);
    idle(2);

    // Key in the expiry cycle wins; then clear ends the entry silently.
    press(4'h9);
    idle(TIMEOUT_CYCLES - 1);
    press(4'h1);
    check("t4b_key_wins_busy", {31'd0, busy}, 32'd1);
    check("t4b_key_wins_count", {29'd0, digit_count}, 32'd2);
    press(4'hA);
    check("t4b_clear_count", {29'd0, digit_count}, 32'd0);
    check("t4b_clear_busy", {31'd0, busy}, 32'd0);
    idle(2);

    // 5: lockout with same-cycle key.
    press(4'h4); press(4'h4);
    lock_in = 1'b1;
    press(4'h4);
    check("t5_lock_count", {29'd0, digit_count}, 32'd0);
    check("t5_lock_busy", {31'd0, busy}, 32'd0);
    press(4'h5); press(4'hB);
    check("t5_locked_count", {29'd0, digit_count}, 32'd0);
    lock_in = 1'b0;
    idle(1);
    expect_error();
    press(4'hB);
    check("t5_pw_held", {16'd0, password_input}, 32'h1111);
    idle(2);

    // 6: backspace key.
    press(4'h3); press(4'h7); press(4'h8); press(4'hC); press(4'h6);
`ifdef KEYPAD_BACKSPACE_EN
    press(4'h1);
    check("t6_count", {29'd0, digit_count}, 32'd4);
    expect_valid(16'h3761);
    press(4'hB);
`else
    check("t6_count", {29'd0, digit_count}, 32'd4);
    expect_error();
    press(4'h1);
    expect_valid(16'h3786);
    press(4'hB);
`endif
    idle(2);

    // Asynchronous reset mid-entry.
    press(4'h1); press(4'h2);
    #2 rst = 1'b0;
    #1;
    exp_pw = 16'h0000;
    check("arst_password", {16'd0, password_input}, 32'h0);
    check("arst_count", {29'd0, digit_count}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_strobes", {30'd0, pwd_valid, entry_error}, 32'd0);
    #3 rst = 1'b1;
    idle(3);
    check("arst_still_idle", {31'd0, busy}, 32'd0);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
